fsm_frame_tx: RTL

//  Moore-FSM serial frame transmitter: the transmit end of the single-wire "101"-preamble link.

---
 rtl/fsm_frame_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fsm_frame_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload LSB first, optional even parity, then a zero gap.
// Optional parity bit is enabled by defining FSM_FRAME_TX_PARITY_EN.
module fsm_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int IDLE_BITS = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and in_data is ignored at all other times.

  localparam int CNT_MAX = (DATA_W > IDLE_BITS) ? ((DATA_W > 2) ? DATA_W : 2)
                                                : ((IDLE_BITS > 2) ? IDLE_BITS : 2);
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE1 = 3'd1,
    PRE0 = 3'd2,
    PRE2 = 3'd3,
    DATA = 3'd4,
    PAR  = 3'd5,
    GAP  = 3'd6
  } state_t;

  localparam state_t AFTER_PAR = (IDLE_BITS > 0) ? GAP : IDLE;
`ifdef FSM_FRAME_TX_PARITY_EN
  localparam state_t AFTER_DATA = PAR;
`else
  localparam state_t AFTER_DATA = AFTER_PAR;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              in_ready_q, in_ready_d;
`ifdef FSM_FRAME_TX_PARITY_EN
  logic [DATA_W-1:0] word_q, word_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef FSM_FRAME_TX_PARITY_EN
    word_d  = word_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = PRE1;
          shift_d = in_data;
`ifdef FSM_FRAME_TX_PARITY_EN
          word_d  = in_data;
`endif
        end
      end
      PRE1: state_d = PRE0;
      PRE0: state_d = PRE2;
      PRE2: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = AFTER_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      PAR: state_d = AFTER_PAR;
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    out_d = 1'b0;
    case (state_d)
      PRE1, PRE2: out_d = 1'b1;
      DATA:       out_d = shift_d[0];
`ifdef FSM_FRAME_TX_PARITY_EN
      PAR:        out_d = ^word_d;
`endif
      default:    out_d = 1'b0;
    endcase
`ifdef FSM_FRAME_TX_PARITY_EN
    frame_done_d = (state_d == PAR);
`else
    frame_done_d = (state_d == DATA) && (cnt_d == DATA_LAST);
`endif
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef FSM_FRAME_TX_PARITY_EN
      word_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      in_ready_q   <= in_ready_d;
`ifdef FSM_FRAME_TX_PARITY_EN
      word_q       <= word_d;
`endif
    end
  end

  assign out        = out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_ready   = in_ready_q;
  assign dbg_state  = state_q;

endmodule
